// File: rtl/sd_k_sweep_sequencer.sv
// sd_k_sweep_sequencer: table-driven kin1/kin2/muxin1 sweep for a two-piece sigma-delta modulator.
module sd_k_sweep_sequencer #(
  parameter int BITWIDTH = 40,
  parameter int DEPTH = 4,
  parameter int CW = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic                       cfg_we,
  input  logic [$clog2(DEPTH)+1:0]   cfg_addr,
  input  logic [BITWIDTH-1:0]        cfg_wdata,
  input  logic                       cfg_commit,
  output logic                       cfg_pending,
  output logic [BITWIDTH-1:0]        kin1,
  output logic [BITWIDTH-1:0]        kin2,
  output logic                       muxin1,
  output logic [$clog2(DEPTH)-1:0]   seg_idx,
  output logic                       period_tick,
  output logic                       active
);
  localparam int SW = $clog2(DEPTH);
  localparam int AW = SW + 2;
  localparam logic [AW-1:0] A_HI = AW'(DEPTH);
  localparam logic [AW-1:0] A_PER = AW'(DEPTH + 1);
  localparam logic [AW-1:0] A_NSEG = AW'(DEPTH + 2);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0] state;
  logic [CW-1:0] ph, hi, period, sh_hi, sh_period, sh_hi_n, sh_period_n, p_eff;
  logic [SW-1:0] seg, nseg, sh_nseg, sh_nseg_n, seg_next;
  logic [BITWIDTH-1:0] k [DEPTH];
  logic [BITWIDTH-1:0] sh_k [DEPTH];
  logic [BITWIDTH-1:0] sh_k_n [DEPTH];
  logic pending, run, bnd, copy;
  // Snapshot source includes a same-cycle shadow write
  always_comb begin
    sh_k_n = sh_k;
    sh_hi_n = sh_hi;
    sh_period_n = sh_period;
    sh_nseg_n = sh_nseg;
    if (cfg_we) begin
      if (cfg_addr[AW-1:SW] == 2'b00) sh_k_n[cfg_addr[SW-1:0]] = cfg_wdata;
      else if (cfg_addr == A_HI) sh_hi_n = cfg_wdata[CW-1:0];
      else if (cfg_addr == A_PER) sh_period_n = cfg_wdata[CW-1:0];
      else if (cfg_addr == A_NSEG)
        sh_nseg_n = cfg_wdata > BITWIDTH'(DEPTH - 1) ? SW'(DEPTH - 1) : cfg_wdata[SW-1:0];
    end
  end
  always_comb begin
    run = state != IDLE;
    p_eff = period == '0 ? CW'(1) : period;
    bnd = run && ph == p_eff - 1'b1;
    seg_next = seg == nseg ? '0 : seg + 1'b1;
    copy = run ? bnd && (pending || cfg_commit) : cfg_commit;
    kin1 = k[seg];
    kin2 = k[seg_next];
    muxin1 = run && ph < hi;
    period_tick = bnd;
    active = run;
    cfg_pending = pending;
    seg_idx = seg;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      ph <= '0;
      seg <= '0;
      pending <= 1'b0;
      hi <= '0;
      period <= CW'(1);
      nseg <= '0;
      sh_hi <= '0;
      sh_period <= CW'(1);
      sh_nseg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        k[i] <= '0;
        sh_k[i] <= '0;
      end
    end else begin
      sh_k <= sh_k_n;
      sh_hi <= sh_hi_n;
      sh_period <= sh_period_n;
      sh_nseg <= sh_nseg_n;
      if (copy) begin
        k <= sh_k_n;
        hi <= sh_hi_n;
        period <= sh_period_n;
        nseg <= sh_nseg_n;
      end
      pending <= run && !bnd && (pending || cfg_commit);
      if (!run) begin
        state <= en ? RUN : IDLE;
        ph <= '0;
        seg <= '0;
      end else begin
        state <= en ? RUN : (bnd ? IDLE : DRAIN);
        ph <= bnd ? '0 : ph + 1'b1;
        seg <= (bnd && (copy || !en)) ? '0 : (bnd ? seg_next : seg);
      end
    end
  end
endmodule

// File: tb/tb_sd_k_sweep_sequencer.sv
// tb_sd_k_sweep_sequencer: directed stimulus with a per-cycle expectation queue checked by a monitor.
module tb_sd_k_sweep_sequencer;
  logic clk = 1'b0;
  logic reset, en, cfg_we, cfg_commit;
  logic [3:0] cfg_addr;
  logic [39:0] cfg_wdata;
  logic cfg_pending, muxin1, period_tick, active;
  logic [39:0] kin1, kin2;
  logic [1:0] seg_idx;
  int checks = 0;
  int errors = 0;
  localparam logic [39:0] K0 = 40'h0000100000;
  localparam logic [39:0] K1 = 40'h0000200000;
  localparam logic [39:0] K3 = 40'h0000300000;
  typedef struct {
    string n;
    logic [39:0] k1, k2;
    logic mux;
    logic [1:0] seg;
    logic tick, act, pend;
  } exp_t;
  exp_t q[$];
  exp_t e;
  sd_k_sweep_sequencer dut (
    .clk(clk), .reset(reset), .en(en), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_commit(cfg_commit), .cfg_pending(cfg_pending),
    .kin1(kin1), .kin2(kin2), .muxin1(muxin1), .seg_idx(seg_idx),
    .period_tick(period_tick), .active(active)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      checks++;
      if ({kin1, kin2, muxin1, seg_idx, period_tick, active, cfg_pending} !==
          {e.k1, e.k2, e.mux, e.seg, e.tick, e.act, e.pend}) begin
        errors++;
        $display("FAIL %s: got k1=%h k2=%h mux=%b seg=%0d tick=%b act=%b pend=%b, want k1=%h k2=%h mux=%b seg=%0d tick=%b act=%b pend=%b",
                 e.n, kin1, kin2, muxin1, seg_idx, period_tick, active, cfg_pending,
                 e.k1, e.k2, e.mux, e.seg, e.tick, e.act, e.pend);
      end
    end
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic ex(string n, logic [39:0] k1, logic [39:0] k2, logic mux, logic [1:0] s,
                    logic tick, logic act, logic pend);
    exp_t x;
    x.n = n; x.k1 = k1; x.k2 = k2; x.mux = mux; x.seg = s;
    x.tick = tick; x.act = act; x.pend = pend;
    q.push_back(x);
  endtask
  // Running with hi = 3, period = 8
  task automatic rx(string n, int ph, logic [39:0] a, logic [39:0] b, logic [1:0] s, logic pd);
    ex(n, a, b, ph < 3, s, ph == 7, 1'b1, pd);
  endtask
  task automatic wr(logic [3:0] a, logic [39:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_wdata = d;
  endtask
  task automatic nowr();
    cfg_we = 1'b0; cfg_commit = 1'b0;
  endtask
  initial begin
    reset = 1'b1; en = 1'b0; cfg_we = 1'b0; cfg_commit = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (3) begin cyc(); ex("reset", '0, '0, 0, 0, 0, 0, 0); end
    reset = 1'b0;
    wr(4'd0, K0); cyc(); ex("idle_wr0", '0, '0, 0, 0, 0, 0, 0);
    wr(4'd1, K1); cyc(); ex("idle_wr1", '0, '0, 0, 0, 0, 0, 0);
    wr(4'd4, 40'd3); cyc(); ex("idle_wr_hi", '0, '0, 0, 0, 0, 0, 0);
    wr(4'd5, 40'd8); cyc(); ex("idle_wr_per", '0, '0, 0, 0, 0, 0, 0);
    wr(4'd6, 40'd1); cfg_commit = 1'b1; cyc(); ex("idle_commit", K0, K1, 0, 0, 0, 0, 0);
    nowr(); en = 1'b1;
    for (int c = 0; c < 18; c++) begin
      cyc();
      rx("dither", c % 8, ((c / 8) % 2) ? K1 : K0, ((c / 8) % 2) ? K0 : K1, 2'((c / 8) % 2), 0);
    end
    wr(4'd0, K3); cfg_commit = 1'b1; cyc(); rx("commit_mid", 2, K0, K1, 0, 1);
    nowr();
    for (int p = 3; p < 8; p++) begin cyc(); rx("pending_hold", p, K0, K1, 0, 1); end
    cyc(); rx("commit_apply", 0, K3, K1, 0, 0);
    for (int p = 1; p < 5; p++) begin cyc(); rx("pre_drain", p, K3, K1, 0, 0); end
    en = 1'b0;
    for (int p = 5; p < 8; p++) begin cyc(); rx("drain", p, K3, K1, 0, 0); end
    cyc(); ex("drain_idle", K3, K1, 0, 0, 0, 0, 0);
    en = 1'b1;
    for (int p = 0; p < 5; p++) begin cyc(); rx("rerun", p, K3, K1, 0, 0); end
    en = 1'b0;
    cyc(); rx("redrain", 5, K3, K1, 0, 0);
    cyc(); rx("redrain", 6, K3, K1, 0, 0);
    en = 1'b1;
    cyc(); rx("reraise", 7, K3, K1, 0, 0);
    cyc(); rx("reraise_wrap", 0, K1, K3, 1, 0);
    cyc(); rx("reraise_wrap", 1, K1, K3, 1, 0);
    wr(4'd0, 40'hABC); cfg_commit = 1'b1; cyc(); rx("pend_before_reset", 2, K1, K3, 1, 1);
    nowr(); reset = 1'b1;
    cyc(); ex("reset_mid_run", '0, '0, 0, 0, 0, 0, 0);
    reset = 1'b0; en = 1'b0;
    cyc(); ex("after_reset", '0, '0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      wr(4'(i), 40'(i + 1)); cyc(); ex("idle_wr_k", '0, '0, 0, 0, 0, 0, 0);
    end
    wr(4'd6, 40'd7); cyc(); ex("idle_wr_nseg", '0, '0, 0, 0, 0, 0, 0);
    wr(4'd5, 40'd1); cyc(); ex("idle_wr_per1", '0, '0, 0, 0, 0, 0, 0);
    wr(4'd4, 40'd0); cfg_commit = 1'b1; cyc(); ex("idle_commit2", 40'd1, 40'd2, 0, 0, 0, 0, 0);
    nowr(); en = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc(); ex("wrap_p1", 40'(c % 4 + 1), 40'((c + 1) % 4 + 1), 0, 2'(c % 4), 1, 1, 0);
    end
    wr(4'd5, 40'd8); cyc(); ex("wr_per8_run", 40'd1, 40'd2, 0, 0, 1, 1, 0);
    wr(4'd4, 40'd9); cyc(); ex("wr_hi9_run", 40'd2, 40'd3, 0, 1, 1, 1, 0);
    nowr(); cfg_commit = 1'b1; cyc(); ex("commit_on_bnd", 40'd1, 40'd2, 1, 0, 0, 1, 0);
    cfg_commit = 1'b0;
    for (int c = 1; c < 9; c++) begin
      cyc();
      ex("hi_over_p", c == 8 ? 40'd2 : 40'd1, c == 8 ? 40'd3 : 40'd2, 1, c == 8 ? 2'd1 : 2'd0,
         (c % 8) == 7, 1, 0);
    end
    en = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d expectations left, want 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
